tft_spi_rx: RTL

- Receive-side (slave) decoder for the 4-wire write-only TFT SPI link (SCK, SDA, CS, DC) driven by our display master.
- Oversamples the link in the system clock domain and assembles bytes.
- Interprets the ILI-style window/RAM-write commands: 0x2A column set, 0x2B row set, 0x2C RAM write.
- Emits decoded window registers and per-pixel write strobes with x/y; used as a display model/monitor and as a loopback checker.

---
 rtl/tft_spi_pkg.sv | 8 +
 rtl/tft_spi_rx_sync.sv | 24 ++
 rtl/tft_spi_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tft_spi_pkg.sv
// tft_spi_pkg: shared command codes, decoder state type and default coordinate width
package tft_spi_pkg;
  localparam int COORD_W_DEF = 9;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR_HI, ST_RAMWR_LO} dec_state_t;
endpackage

// File: rtl/tft_spi_rx_sync.sv
// tft_spi_rx_sync: synchronizer chain for the SPI pins; bit 0 (SCK) becomes a rising-edge pulse
module tft_spi_rx_sync #(
  parameter int STAGES = 2,
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:1] q,
  output logic         rise
);
  logic [STAGES-1:0][W-1:0] ff;
  logic prev;
  always_ff @(posedge Clk)
    if (Reset) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1][0];
    end
  assign q = ff[STAGES-1][W-1:1];
  assign rise = ff[STAGES-1][0] & ~prev;
endmodule

// File: rtl/tft_spi_rx.sv
// tft_spi_rx: TFT SPI slave decoder (bytes, CASET/PASET window, RAMWR pixels); TFT_SPI_RX_STATS_EN adds counters
module tft_spi_rx
  import tft_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               spi_sck,
  input  logic               spi_sda,
  input  logic               spi_cs,
  input  logic               spi_dc,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic [COORD_W-1:0] col_start,
  output logic [COORD_W-1:0] col_end,
  output logic [COORD_W-1:0] row_start,
  output logic [COORD_W-1:0] row_end,
  output logic               pix_valid,
  output logic [15:0]        pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
`ifdef TFT_SPI_RX_STATS_EN
  output logic [15:0]        cmd_count,
  output logic [23:0]        pix_count,
  output logic [7:0]         err_count,
`endif
  output logic               frame_err
);
  logic sck_rise, sda, cs, dc;
  logic [2:0] cnt;
  logic [7:0] sr, hi;
  logic full, dc_lat, armed, err_now;
  logic [23:0] stage;
  logic [1:0] idx;
  logic [COORD_W-1:0] cx, cy, nx, ny;
  dec_state_t state;

  tft_spi_rx_sync #(.STAGES(SYNC_STAGES), .W(4)) u_sync (
    .Clk(Clk),
    .Reset(Reset),
    .d({spi_dc, spi_cs, spi_sda, spi_sck}),
    .q({dc, cs, sda}),
    .rise(sck_rise)
  );

  assign err_now = cs && cnt != 3'd0;

  // armed stays low after reset until CS is seen high, so a mid-frame reset cannot misalign bytes
  always_ff @(posedge Clk)
    if (Reset) begin
      cnt <= '0;
      sr <= '0;
      full <= 1'b0;
      dc_lat <= 1'b0;
      armed <= 1'b0;
      frame_err <= 1'b0;
      byte_valid <= 1'b0;
      byte_data <= '0;
      byte_dc <= 1'b0;
    end else begin
      frame_err <= err_now;
      byte_valid <= full;
      full <= 1'b0;
      if (full) begin
        byte_data <= sr;
        byte_dc <= dc_lat;
      end
      if (cs) begin
        cnt <= '0;
        sr <= '0;
        armed <= 1'b1;
      end else if (sck_rise && armed) begin
        sr <= {sr[6:0], sda};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          full <= 1'b1;
          dc_lat <= dc;
        end
      end
    end

  assign nx = cx == col_end ? col_start : cx + 1'b1;
  assign ny = cx != col_end ? cy : cy == row_end ? row_start : cy + 1'b1;

  always_ff @(posedge Clk)
    if (Reset) begin
      state <= ST_IDLE;
      idx <= '0;
      stage <= '0;
      hi <= '0;
      cx <= '0;
      cy <= '0;
      col_start <= '0;
      col_end <= '1;
      row_start <= '0;
      row_end <= '1;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (full) begin
        if (!dc_lat) begin
          idx <= '0;
          state <= sr == CMD_CASET ? ST_CASET : sr == CMD_PASET ? ST_PASET :
                   sr == CMD_RAMWR ? ST_RAMWR_HI : ST_IDLE;
          if (sr == CMD_RAMWR) begin
            cx <= col_start;
            cy <= row_start;
          end
        end else
          case (state)
            ST_CASET, ST_PASET: begin
              stage <= {stage[15:0], sr};
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                state <= ST_IDLE;
                if (state == ST_CASET) begin
                  col_start <= COORD_W'(stage[23:8]);
                  col_end <= COORD_W'({stage[7:0], sr});
                end else begin
                  row_start <= COORD_W'(stage[23:8]);
                  row_end <= COORD_W'({stage[7:0], sr});
                end
              end
            end
            ST_RAMWR_HI: begin
              hi <= sr;
              state <= ST_RAMWR_LO;
            end
            ST_RAMWR_LO: begin
              pix_valid <= 1'b1;
              pix_data <= {hi, sr};
              pix_x <= cx;
              pix_y <= cy;
              cx <= nx;
              cy <= ny;
              state <= ST_RAMWR_HI;
            end
            default: ;
          endcase
      end
    end

`ifdef TFT_SPI_RX_STATS_EN
  always_ff @(posedge Clk)
    if (Reset) begin
      cmd_count <= '0;
      pix_count <= '0;
      err_count <= '0;
    end else begin
      if (full && !dc_lat) cmd_count <= cmd_count + 16'd1;
      if (full && dc_lat && state == ST_RAMWR_LO) pix_count <= pix_count + 24'd1;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif
endmodule
